switch_mcu_ahb_imem_slave: RTL and testbench
============================================

Name: switch_mcu_ahb_imem_slave

Overview:
AHB-Lite instruction-memory responder that serves the IFU's fetch master. Word-organised ROM image, loaded through a simple load port after reset. Once the last word is loaded, the block raises out_init_done, which drives the core's in_init_done. Responds to fetches with configurable wait states and returns a two-cycle ERROR for illegal transfers.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of word 0.
DEPTH_WORDS, 1024, number of 32-bit words (power of two, 16..65536).
WAIT_STATES, 1, wait cycles inserted before OKAY data (0..7).

Ports:
in_clk  input  1  clock, all logic on rising edge
in_rst  input  1  synchronous active-high reset
in_load_valid  input  1  load-word strobe
in_load_addr  input  log2(DEPTH_WORDS)  word index to load
in_load_data  input  32  word to store
in_load_last  input  1  marks final load word (qualified by valid)
out_init_done  output  1  image loaded, fetch permitted
in_hsel  input  1  slave select
in_haddr  input  32  byte address
in_hwrite  input  1  write request (always illegal here)
in_hsize  input  4  transfer size, only 4'd2 (word) legal
in_hport  input  4  protection, ignored
in_hburst  input  3  burst type, ignored (each beat handled singly)
in_htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
in_hmastlock  input  1  ignored
out_hready  output  1  data phase complete / address accepted
out_hresp  output  1  0 OKAY, 1 ERROR
out_hrdata  output  32  read data

Behaviour:
- Reset (in_rst=1 at clock edge): out_hready=1, out_hresp=0, out_hrdata=0, out_init_done=0, FSM=ST_READY, wait counter=0. Memory array is not cleared; reload is required because init_done drops.
- Load: while out_init_done=0 and in_load_valid=1, mem[in_load_addr] <= in_load_data. If in_load_last=1 on that beat, out_init_done=1 on the next cycle and stays 1 until reset. Load beats while out_init_done=1 are ignored.
- Address phase is sampled only on an edge where out_hready=1. A transfer is valid when in_hsel=1 and in_htrans[1]=1. IDLE, BUSY, or unselected: no data phase, and the FSM stays in ST_READY.
- Error check on sampled valid transfer: any of in_hwrite=1; in_hsize!=4'd2; in_haddr[1:0]!=0; in_haddr<ADDR_BASE; in_haddr>=ADDR_BASE+4*DEPTH_WORDS; out_init_done=0.
- Word index is (in_haddr-ADDR_BASE)>>2. Read is synchronous: the word is latched at address sampling and presented when the data phase completes.
- FSM:
  - ST_READY: out_hready=1, out_hresp=0. Behaviour on a sampled valid transfer:
    - Error: go to ST_ERR1.
    - Else if WAIT_STATES=0: stay in ST_READY with out_hrdata=mem[idx] on the next cycle (zero-wait, pipelined back-to-back fetch).
    - Else: go to ST_WAIT, counter=WAIT_STATES-1.
  - ST_WAIT: out_hready=0, out_hresp=0, and the address inputs are ignored. When counter=0, go to ST_READY and drive out_hrdata=latched word with out_hready=1. Otherwise decrement the counter. Every OKAY data phase therefore lasts exactly WAIT_STATES+1 cycles.
  - ST_ERR1: out_hready=0, out_hresp=1, out_hrdata=0. Go to ST_ERR2.
  - ST_ERR2: out_hready=1, out_hresp=1, out_hrdata=0. The next address is sampled here with the same rules as ST_READY. A master that drives IDLE here gets ST_READY.
- out_hrdata holds its last value in ST_READY cycles that carry no completing data phase.
- Simultaneous load and fetch are impossible by construction: a fetch before init_done errors.
- Reset mid-wait or mid-error aborts the data phase and returns to the reset state the next cycle.

Test Plan:
- Reset, load 4 words (0x00000013, 0x00100093, 0x00208113, 0xDEADBEEF), last on word 3. Check out_init_done=1 exactly one cycle after the last beat and holds.
- WAIT_STATES=1, NONSEQ read 0x00000004 → out_hready low 1 cycle, then high with out_hrdata=0x00100093, out_hresp=0.
- WAIT_STATES=0, back-to-back NONSEQ/SEQ at 0x0, 0x4, 0x8 → out_hready constantly 1, data 0x00000013, 0x00100093, 0x00208113 on consecutive cycles.
- Fetch at 0x00000002, a write to 0x0, and an address 4*DEPTH_WORDS → each gives out_hready/out_hresp sequence 0/1 then 1/1, out_hrdata=0.
- Fetch 0x0 before init done → ERROR. After loading, the same fetch → OKAY 0x00000013.
- Assert in_rst during ST_WAIT → next cycle out_hready=1, out_hresp=0, out_hrdata=0, out_init_done=0. Memory reread after reload returns the new image.

Source files
------------

// File: rtl/switch_mcu_ahb_imem_slave_if.sv
// AHB-Lite bus bundle between the IFU fetch master and the instruction-memory slave.
interface switch_mcu_ahb_imem_slave_if;
    logic        in_hsel;
    logic [31:0] in_haddr;
    logic        in_hwrite;
    logic [3:0]  in_hsize;
    logic [3:0]  in_hport;
    logic [2:0]  in_hburst;
    logic [1:0]  in_htrans;
    logic        in_hmastlock;
    logic        out_hready;
    logic        out_hresp;
    logic [31:0] out_hrdata;

    modport master (
        output in_hsel, in_haddr, in_hwrite, in_hsize, in_hport, in_hburst, in_htrans,
               in_hmastlock,
        input  out_hready, out_hresp, out_hrdata
    );

    modport slave (
        input  in_hsel, in_haddr, in_hwrite, in_hsize, in_hport, in_hburst, in_htrans,
               in_hmastlock,
        output out_hready, out_hresp, out_hrdata
    );
endinterface

// File: rtl/switch_mcu_ahb_imem_slave.sv
// Instruction-memory AHB-Lite responder: word ROM image written through a load port,
// read-only fetch with configurable wait states and a two-cycle ERROR response.
module switch_mcu_ahb_imem_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                           in_clk,
    input  logic                           in_rst,
    input  logic                           in_load_valid,
    input  logic [$clog2(DEPTH_WORDS)-1:0] in_load_addr,
    input  logic [31:0]                    in_load_data,
    input  logic                           in_load_last,
    output logic                           out_init_done,
    switch_mcu_ahb_imem_slave_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] ST_READY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_ERR1  = 2'd2;
    localparam logic [1:0] ST_ERR2  = 2'd3;

    localparam logic [2:0]  WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
    localparam logic [32:0] SPAN      = 33'(4 * DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [1:0]    state;
    logic [2:0]    cnt;
    logic [31:0]   rdata;
    logic [31:0]   word;
    logic          init_done;

    logic          accept;
    logic          valid;
    logic          err;
    logic [32:0]   offset;
    logic [AW-1:0] idx;
    logic          unused_bits;

    // Address phase is only sampled while hready is high (READY or second ERROR cycle).
    assign accept = (state == ST_READY) || (state == ST_ERR2);
    assign valid  = bus.in_hsel & bus.in_htrans[1];

    // 33-bit subtraction: bit 32 set means the address lies below ADDR_BASE.
    assign offset = {1'b0, bus.in_haddr} - {1'b0, ADDR_BASE};
    assign idx    = offset[AW+1:2];

    assign err = bus.in_hwrite
               | (bus.in_hsize != 4'd2)
               | (bus.in_haddr[1:0] != 2'b00)
               | offset[32]
               | (offset >= SPAN)
               | ~init_done;

    assign unused_bits = ^{bus.in_hport, bus.in_hburst, bus.in_hmastlock, offset[1:0]};

    assign bus.out_hready = accept;
    assign bus.out_hresp  = (state == ST_ERR1) || (state == ST_ERR2);
    assign bus.out_hrdata = rdata;
    assign out_init_done  = init_done;

    // Image load; the array itself is never cleared by reset.
    always_ff @(posedge in_clk) begin
        if (!in_rst && !init_done && in_load_valid) begin
            mem[in_load_addr] <= in_load_data;
        end
    end

    // Init flag, transfer FSM, wait counter and read-data register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state     <= ST_READY;
            cnt       <= 3'd0;
            rdata     <= 32'd0;
            word      <= 32'd0;
            init_done <= 1'b0;
        end else begin
            if (!init_done && in_load_valid && in_load_last) begin
                init_done <= 1'b1;
            end

            case (state)
                ST_READY, ST_ERR2: begin
                    state <= ST_READY;
                    if (valid) begin
                        if (err) begin
                            state <= ST_ERR1;
                            rdata <= 32'd0;
                        end else if (WAIT_STATES == 0) begin
                            rdata <= mem[idx];
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_INIT;
                            word  <= mem[idx];
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= ST_READY;
                        rdata <= word;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_switch_mcu_ahb_imem_slave.sv
// Scoreboard bench: one slave with one wait state, one zero-wait slave, shared stimulus.
module tb_switch_mcu_ahb_imem_slave;
    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic        resp;
        logic [31:0] data;
        int          waits;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [3:0]  load_addr = 4'd0;
    logic [31:0] load_data = 32'd0;
    logic        load_last = 1'b0;
    logic        init1, init0;
    logic        tgt = 1'b1;
    logic        hsel = 1'b0;
    logic [31:0] haddr = 32'd0;
    logic        hwrite = 1'b0;
    logic [3:0]  hsize = 4'd2;
    logic [1:0]  htrans = 2'b00;

    int checks = 0;
    int failures = 0;

    exp_t q1[$];
    exp_t q0[$];
    exp_t e1, e0;
    bit   pend1 = 0, pend0 = 0;
    int   waits1 = 0, waits0 = 0;

    switch_mcu_ahb_imem_slave_if bus1 ();
    switch_mcu_ahb_imem_slave_if bus0 ();

    assign bus1.in_hsel      = hsel & tgt;
    assign bus1.in_haddr     = haddr;
    assign bus1.in_hwrite    = hwrite;
    assign bus1.in_hsize     = hsize;
    assign bus1.in_hport     = 4'd0;
    assign bus1.in_hburst    = 3'd0;
    assign bus1.in_htrans    = htrans;
    assign bus1.in_hmastlock = 1'b0;
    assign bus0.in_hsel      = hsel & ~tgt;
    assign bus0.in_haddr     = haddr;
    assign bus0.in_hwrite    = hwrite;
    assign bus0.in_hsize     = hsize;
    assign bus0.in_hport     = 4'd0;
    assign bus0.in_hburst    = 3'd0;
    assign bus0.in_htrans    = htrans;
    assign bus0.in_hmastlock = 1'b0;

    switch_mcu_ahb_imem_slave #(
        .ADDR_BASE   (32'h0000_0000),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (1)
    ) dut1 (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_load_valid (load_valid),
        .in_load_addr  (load_addr),
        .in_load_data  (load_data),
        .in_load_last  (load_last),
        .out_init_done (init1),
        .bus           (bus1)
    );

    switch_mcu_ahb_imem_slave #(
        .ADDR_BASE   (32'h0000_0000),
        .DEPTH_WORDS (DEPTH),
        .WAIT_STATES (0)
    ) dut0 (
        .in_clk        (clk),
        .in_rst        (rst),
        .in_load_valid (load_valid),
        .in_load_addr  (load_addr),
        .in_load_data  (load_data),
        .in_load_last  (load_last),
        .out_init_done (init0),
        .bus           (bus0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic rdy();
        return tgt ? bus1.out_hready : bus0.out_hready;
    endfunction

    task automatic push(input logic sel, input logic resp, input logic [31:0] data,
                        input int waits);
        exp_t e;
        e.resp = resp;
        e.data = data;
        e.waits = waits;
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
    endtask

    // Present an address phase and return just after the edge that samples it.
    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [3:0] sz,
                              input logic [1:0] tr);
        bit ok;
        ok = 0;
        hsel = 1'b1;
        haddr = a;
        hwrite = w;
        hsize = sz;
        htrans = tr;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy()) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL addr_timeout got=hready_low exp=hready_high addr=%h", a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        hsel = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hsize = 4'd2;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_image(input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] img [4];
        img[0] = w0;
        img[1] = w1;
        img[2] = w2;
        img[3] = w3;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_addr = 4'(i);
            load_data = img[i];
            load_last = (i == 3);
            @(negedge clk);
            chk("init_low_during_load", {31'd0, init1}, 32'd0);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last = 1'b0;
        @(negedge clk);
        chk("init1_after_last", {31'd0, init1}, 32'd1);
        chk("init0_after_last", {31'd0, init0}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor for the one-wait-state slave.
    always @(negedge clk) begin
        if (rst) begin
            pend1 = 0;
        end else begin
            if (pend1) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb1_unexpected got=response exp=none");
                    pend1 = 0;
                end else if (!bus1.out_hready) begin
                    waits1++;
                    chk("sb1_wait_hresp", {31'd0, bus1.out_hresp}, {31'd0, q1[0].resp});
                end else begin
                    e1 = q1.pop_front();
                    chk("sb1_hresp", {31'd0, bus1.out_hresp}, {31'd0, e1.resp});
                    chk("sb1_hrdata", bus1.out_hrdata, e1.data);
                    chk("sb1_waits", 32'(waits1), 32'(e1.waits));
                    pend1 = 0;
                end
            end
            if (bus1.out_hready && bus1.in_hsel && bus1.in_htrans[1]) begin
                pend1 = 1;
                waits1 = 0;
            end
        end
    end

    // Monitor for the zero-wait slave.
    always @(negedge clk) begin
        if (rst) begin
            pend0 = 0;
        end else begin
            if (pend0) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb0_unexpected got=response exp=none");
                    pend0 = 0;
                end else if (!bus0.out_hready) begin
                    waits0++;
                    chk("sb0_wait_hresp", {31'd0, bus0.out_hresp}, {31'd0, q0[0].resp});
                end else begin
                    e0 = q0.pop_front();
                    chk("sb0_hresp", {31'd0, bus0.out_hresp}, {31'd0, e0.resp});
                    chk("sb0_hrdata", bus0.out_hrdata, e0.data);
                    chk("sb0_waits", 32'(waits0), 32'(e0.waits));
                    pend0 = 0;
                end
            end
            if (bus0.out_hready && bus0.in_hsel && bus0.in_htrans[1]) begin
                pend0 = 1;
                waits0 = 0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hready", {31'd0, bus1.out_hready}, 32'd1);
        chk("rst_hresp", {31'd0, bus1.out_hresp}, 32'd0);
        chk("rst_hrdata", bus1.out_hrdata, 32'd0);
        chk("rst_init1", {31'd0, init1}, 32'd0);
        chk("rst_init0", {31'd0, init0}, 32'd0);
        @(posedge clk);
        #1;

        // Fetches before the image is loaded must error.
        tgt = 1'b1;
        push(1'b1, 1'b1, 32'd0, 1);
        addr_phase(32'h0, 1'b0, 4'd2, 2'b10);
        idle(3);
        tgt = 1'b0;
        push(1'b0, 1'b1, 32'd0, 1);
        addr_phase(32'h0, 1'b0, 4'd2, 2'b10);
        idle(3);

        load_image(32'h0000_0013, 32'h0010_0093, 32'h0020_8113, 32'hDEAD_BEEF);

        // Late load beat must be ignored; init_done holds.
        load_valid = 1'b1;
        load_addr = 4'd0;
        load_data = 32'hFFFF_FFFF;
        load_last = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("init1_holds", {31'd0, init1}, 32'd1);
        @(posedge clk);
        #1;

        // One wait state.
        tgt = 1'b1;
        push(1'b1, 1'b0, 32'h0000_0013, 1);
        addr_phase(32'h0, 1'b0, 4'd2, 2'b10);
        idle(3);
        push(1'b1, 1'b0, 32'h0010_0093, 1);
        addr_phase(32'h4, 1'b0, 4'd2, 2'b10);
        idle(3);

        // BUSY with select must not start a data phase.
        htrans = 2'b01;
        hsel = 1'b1;
        haddr = 32'h8;
        @(posedge clk);
        #1;
        idle(0);
        @(negedge clk);
        chk("busy_no_phase", {31'd0, bus1.out_hready}, 32'd1);
        @(posedge clk);
        #1;

        // Zero-wait back-to-back burst.
        tgt = 1'b0;
        push(1'b0, 1'b0, 32'h0000_0013, 0);
        push(1'b0, 1'b0, 32'h0010_0093, 0);
        push(1'b0, 1'b0, 32'h0020_8113, 0);
        addr_phase(32'h0, 1'b0, 4'd2, 2'b10);
        addr_phase(32'h4, 1'b0, 4'd2, 2'b11);
        addr_phase(32'h8, 1'b0, 4'd2, 2'b11);
        idle(3);

        // Illegal transfers on the zero-wait slave.
        push(1'b0, 1'b1, 32'd0, 1);
        addr_phase(32'h4, 1'b0, 4'd0, 2'b10);
        idle(3);

        // Illegal transfers on the wait-state slave.
        tgt = 1'b1;
        push(1'b1, 1'b1, 32'd0, 1);
        addr_phase(32'h2, 1'b0, 4'd2, 2'b10);
        idle(3);
        push(1'b1, 1'b1, 32'd0, 1);
        addr_phase(32'h0, 1'b1, 4'd2, 2'b10);
        idle(3);
        push(1'b1, 1'b1, 32'd0, 1);
        addr_phase(32'(4 * DEPTH), 1'b0, 4'd2, 2'b10);
        idle(3);

        // Error immediately followed by a legal fetch sampled in the second ERROR cycle.
        push(1'b1, 1'b1, 32'd0, 1);
        push(1'b1, 1'b0, 32'hDEAD_BEEF, 1);
        addr_phase(32'h2, 1'b0, 4'd2, 2'b10);
        addr_phase(32'hC, 1'b0, 4'd2, 2'b10);
        idle(3);

        // Reset while in the wait state.
        addr_phase(32'h4, 1'b0, 4'd2, 2'b10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midwait_hready", {31'd0, bus1.out_hready}, 32'd1);
        chk("midwait_hresp", {31'd0, bus1.out_hresp}, 32'd0);
        chk("midwait_hrdata", bus1.out_hrdata, 32'd0);
        chk("midwait_init", {31'd0, init1}, 32'd0);
        @(posedge clk);
        #1;

        // Reload a new image and reread.
        load_image(32'hA5A5_0001, 32'h1111_2222, 32'h3333_4444, 32'hCAFE_F00D);
        push(1'b1, 1'b0, 32'hA5A5_0001, 1);
        addr_phase(32'h0, 1'b0, 4'd2, 2'b10);
        idle(3);
        push(1'b1, 1'b0, 32'h3333_4444, 1);
        addr_phase(32'h8, 1'b0, 4'd2, 2'b10);
        idle(3);
        tgt = 1'b0;
        push(1'b0, 1'b0, 32'hCAFE_F00D, 0);
        addr_phase(32'hC, 1'b0, 4'd2, 2'b10);
        idle(5);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q0_drained", 32'(q0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
